// File: rtl/regfile_sb.sv
// Register file with zero register, synchronous clear, optional
// write-to-read bypass and a per-register busy scoreboard.
module regfile_sb #(
   parameter  int XLEN   = 32,
   parameter  int NREG   = 32,
   parameter  int NRD    = 2,
   parameter  int BYPASS = 1,
   localparam int AW     = $clog2(NREG)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              we,
   input  logic [AW-1:0]     wa,
   input  logic [XLEN-1:0]   wd,
   input  logic [NRD*AW-1:0] ra,
   output logic [NRD*XLEN-1:0] rd,
   output logic [NRD-1:0]    rbusy,
   input  logic              rsv_en,
   input  logic [AW-1:0]     rsv_addr,
   output logic [NREG-1:0]   busy_vec
);

   localparam bit BP = (BYPASS != 0);

   logic [XLEN-1:0] rf [NREG];
   logic [NREG-1:0] busy;

   logic wr_ok;
   logic rsv_ok;

   assign wr_ok  = we && (wa != '0);
   assign rsv_ok = rsv_en && (rsv_addr != '0);

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int n = 0; n < NREG; n++)
            rf[n] <= '0;
         busy <= '0;
      end else begin
         if (wr_ok) begin
            rf[wa]   <= wd;
            busy[wa] <= 1'b0;
         end
         // Later assignment wins: a new producer supersedes the retiring one.
         if (rsv_ok)
            busy[rsv_addr] <= 1'b1;
      end
   end

   assign busy_vec = busy;

   for (genvar i = 0; i < NRD; i++) begin : g_rd
      logic [AW-1:0] a;
      logic          hit;

      assign a   = ra[i*AW +: AW];
      assign hit = BP && wr_ok && (wa == a);

      always_comb begin
         rd[i*XLEN +: XLEN] = rf[a];
         rbusy[i]           = busy[a] & ~hit;
         if (a == '0) begin
            rd[i*XLEN +: XLEN] = '0;
            rbusy[i]           = 1'b0;
         end else if (hit) begin
            rd[i*XLEN +: XLEN] = wd;
         end
      end
   end

endmodule

// File: tb/tb_regfile_sb.sv
// Directed bench for regfile_sb: one bypassing and one
// non-bypassing instance driven by the same stimulus.
module tb_regfile_sb;

   localparam int XLEN = 32;
   localparam int NREG = 32;
   localparam int NRD  = 2;
   localparam int AW   = 5;

   logic              clk = 1'b0;
   logic              rst;
   logic              we;
   logic [AW-1:0]     wa;
   logic [XLEN-1:0]   wd;
   logic [NRD*AW-1:0] ra;
   logic              rsv_en;
   logic [AW-1:0]     rsv_addr;

   logic [NRD*XLEN-1:0] rd_b, rd_n;
   logic [NRD-1:0]      rbusy_b, rbusy_n;
   logic [NREG-1:0]     bv_b, bv_n;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   regfile_sb #(.XLEN(XLEN), .NREG(NREG), .NRD(NRD), .BYPASS(1)) u_bp (
      .clk(clk), .rst(rst), .we(we), .wa(wa), .wd(wd), .ra(ra),
      .rd(rd_b), .rbusy(rbusy_b), .rsv_en(rsv_en),
      .rsv_addr(rsv_addr), .busy_vec(bv_b)
   );

   regfile_sb #(.XLEN(XLEN), .NREG(NREG), .NRD(NRD), .BYPASS(0)) u_nb (
      .clk(clk), .rst(rst), .we(we), .wa(wa), .wd(wd), .ra(ra),
      .rd(rd_n), .rbusy(rbusy_n), .rsv_en(rsv_en),
      .rsv_addr(rsv_addr), .busy_vec(bv_n)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      rst = 0; we = 0; wa = '0; wd = '0; rsv_en = 0; rsv_addr = '0;
   endtask

   task automatic set_ra(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
      ra = {a1, a0};
   endtask

   task automatic test_reset();
      idle();
      rst = 1;
      tick();
      rst = 0;
      set_ra(5'd5, 5'd31);
      #1;
      checks++;
      if (rd_b !== '0) begin
         errors++; $display("FAIL reset_rd_bp got %h exp 0", rd_b);
      end
      checks++;
      if (rd_n !== '0) begin
         errors++; $display("FAIL reset_rd_nb got %h exp 0", rd_n);
      end
      checks++;
      if (rbusy_b !== 2'b00 || rbusy_n !== 2'b00) begin
         errors++; $display("FAIL reset_rbusy got %b/%b exp 00", rbusy_b, rbusy_n);
      end
      checks++;
      if (bv_b !== '0 || bv_n !== '0) begin
         errors++; $display("FAIL reset_busy got %h/%h exp 0", bv_b, bv_n);
      end
   endtask

   task automatic test_write();
      we = 1; wa = 5'd5; wd = 32'hDEADBEEF;
      tick();
      idle();
      set_ra(5'd5, 5'd0);
      #1;
      checks++;
      if (rd_b[31:0] !== 32'hDEADBEEF || rd_n[31:0] !== 32'hDEADBEEF) begin
         errors++; $display("FAIL write_rd0 got %h/%h exp deadbeef", rd_b[31:0], rd_n[31:0]);
      end
      checks++;
      if (rd_b[63:32] !== '0 || rd_n[63:32] !== '0) begin
         errors++; $display("FAIL write_rd1 got %h/%h exp 0", rd_b[63:32], rd_n[63:32]);
      end
      checks++;
      if (rbusy_b !== 2'b00 || rbusy_n !== 2'b00) begin
         errors++; $display("FAIL write_rbusy got %b/%b exp 00", rbusy_b, rbusy_n);
      end
   endtask

   task automatic test_zero();
      we = 1; wa = 5'd0; wd = 32'h12345678;
      rsv_en = 1; rsv_addr = 5'd0;
      set_ra(5'd0, 5'd0);
      #1;
      checks++;
      if (rd_b !== '0 || rd_n !== '0) begin
         errors++; $display("FAIL zero_same_cycle got %h/%h exp 0", rd_b, rd_n);
      end
      tick();
      idle();
      #1;
      checks++;
      if (rd_b !== '0 || rd_n !== '0) begin
         errors++; $display("FAIL zero_rd got %h/%h exp 0", rd_b, rd_n);
      end
      checks++;
      if (bv_b !== '0 || bv_n !== '0) begin
         errors++; $display("FAIL zero_busy got %h/%h exp 0", bv_b, bv_n);
      end
   endtask

   task automatic test_bypass();
      we = 1; wa = 5'd7; wd = 32'h11;
      tick();
      we = 1; wa = 5'd7; wd = 32'h22;
      set_ra(5'd7, 5'd5);
      #1;
      checks++;
      if (rd_b[31:0] !== 32'h22) begin
         errors++; $display("FAIL bypass_bp got %h exp 22", rd_b[31:0]);
      end
      checks++;
      if (rd_n[31:0] !== 32'h11) begin
         errors++; $display("FAIL bypass_nb got %h exp 11", rd_n[31:0]);
      end
      tick();
      idle();
      #1;
      checks++;
      if (rd_b[31:0] !== 32'h22 || rd_n[31:0] !== 32'h22) begin
         errors++; $display("FAIL bypass_next got %h/%h exp 22", rd_b[31:0], rd_n[31:0]);
      end
   endtask

   task automatic test_scoreboard();
      rsv_en = 1; rsv_addr = 5'd3;
      set_ra(5'd3, 5'd5);
      #1;
      checks++;
      if (rbusy_b[0] !== 1'b0 || rbusy_n[0] !== 1'b0) begin
         errors++; $display("FAIL sb_rsv_same got %b/%b exp 0", rbusy_b[0], rbusy_n[0]);
      end
      tick();
      idle();
      #1;
      checks++;
      if (bv_b !== 32'h8 || bv_n !== 32'h8) begin
         errors++; $display("FAIL sb_busy_set got %h/%h exp 8", bv_b, bv_n);
      end
      checks++;
      if (rbusy_b !== 2'b01 || rbusy_n !== 2'b01) begin
         errors++; $display("FAIL sb_rbusy_set got %b/%b exp 01", rbusy_b, rbusy_n);
      end
      we = 1; wa = 5'd3; wd = 32'h55;
      #1;
      checks++;
      if (rbusy_b[0] !== 1'b0 || rd_b[31:0] !== 32'h55) begin
         errors++; $display("FAIL sb_wb_bp got %b/%h exp 0/55", rbusy_b[0], rd_b[31:0]);
      end
      checks++;
      if (rbusy_n[0] !== 1'b1 || rd_n[31:0] !== 32'h0) begin
         errors++; $display("FAIL sb_wb_nb got %b/%h exp 1/0", rbusy_n[0], rd_n[31:0]);
      end
      tick();
      idle();
      #1;
      checks++;
      if (bv_b !== '0 || bv_n !== '0) begin
         errors++; $display("FAIL sb_busy_clr got %h/%h exp 0", bv_b, bv_n);
      end
      checks++;
      if (rd_n[31:0] !== 32'h55 || rbusy_n[0] !== 1'b0) begin
         errors++; $display("FAIL sb_after_wb got %h/%b exp 55/0", rd_n[31:0], rbusy_n[0]);
      end
   endtask

   task automatic test_simultaneous();
      rsv_en = 1; rsv_addr = 5'd9;
      tick();
      rsv_en = 1; rsv_addr = 5'd9;
      we = 1; wa = 5'd9; wd = 32'hAA;
      tick();
      idle();
      set_ra(5'd9, 5'd9);
      #1;
      checks++;
      if (bv_b !== 32'h200 || bv_n !== 32'h200) begin
         errors++; $display("FAIL simul_busy got %h/%h exp 200", bv_b, bv_n);
      end
      checks++;
      if (rd_b !== {2{32'hAA}} || rd_n !== {2{32'hAA}}) begin
         errors++; $display("FAIL simul_rd got %h/%h exp aa,aa", rd_b, rd_n);
      end
      checks++;
      if (rbusy_b !== 2'b11 || rbusy_n !== 2'b11) begin
         errors++; $display("FAIL simul_rbusy got %b/%b exp 11", rbusy_b, rbusy_n);
      end
      rsv_en = 1; rsv_addr = 5'd9;
      tick();
      idle();
      #1;
      checks++;
      if (bv_b !== 32'h200) begin
         errors++; $display("FAIL rsv_twice got %h exp 200", bv_b);
      end
      we = 1; wa = 5'd9; wd = 32'hBB;
      tick();
      idle();
      #1;
      checks++;
      if (bv_b !== '0 || rd_b[31:0] !== 32'hBB) begin
         errors++; $display("FAIL simul_retire got %h/%h exp 0/bb", bv_b, rd_b[31:0]);
      end
   endtask

   task automatic test_back_to_back();
      we = 1; wa = 5'd10; wd = 32'hA0A0A0A0;
      tick();
      we = 1; wa = 5'd11; wd = 32'hB1B1B1B1;
      tick();
      idle();
      set_ra(5'd10, 5'd11);
      #1;
      checks++;
      if (rd_b !== {32'hB1B1B1B1, 32'hA0A0A0A0} || rd_n !== rd_b) begin
         errors++; $display("FAIL b2b_rd got %h/%h exp b1b1b1b1a0a0a0a0", rd_b, rd_n);
      end
      checks++;
      if (bv_b !== '0) begin
         errors++; $display("FAIL b2b_busy got %h exp 0", bv_b);
      end
   endtask

   task automatic test_reset_mid();
      we = 1; wa = 5'd4; wd = 32'h44;
      tick();
      we = 1; wa = 5'd6; wd = 32'h66;
      tick();
      idle();
      rsv_en = 1; rsv_addr = 5'd6;
      tick();
      idle();
      set_ra(5'd4, 5'd6);
      #1;
      checks++;
      if (rd_n !== {32'h66, 32'h44} || bv_n !== 32'h40) begin
         errors++; $display("FAIL mid_pre got %h/%h exp 0000006600000044/40", rd_n, bv_n);
      end
      rst = 1;
      we = 1; wa = 5'd4; wd = 32'hFF;
      rsv_en = 1; rsv_addr = 5'd8;
      tick();
      idle();
      #1;
      checks++;
      if (rd_b !== '0 || rd_n !== '0) begin
         errors++; $display("FAIL mid_rd got %h/%h exp 0", rd_b, rd_n);
      end
      checks++;
      if (bv_b !== '0 || bv_n !== '0) begin
         errors++; $display("FAIL mid_busy got %h/%h exp 0", bv_b, bv_n);
      end
      checks++;
      if (rbusy_b !== 2'b00 || rbusy_n !== 2'b00) begin
         errors++; $display("FAIL mid_rbusy got %b/%b exp 00", rbusy_b, rbusy_n);
      end
   endtask

   initial begin
      idle();
      rst = 1;
      set_ra(5'd0, 5'd0);
      tick();
      test_reset();
      test_write();
      test_zero();
      test_bypass();
      test_scoreboard();
      test_simultaneous();
      test_back_to_back();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
